// File: rtl/rvc_asap_pkg.sv
// Shared types and helpers for the rvc_asap unified memory controller:
// access size decode, read-pipeline stage record and load lane formatting.
package rvc_asap_pkg;

  typedef enum logic [1:0] {BYTE, HALF, WORD} t_mem_size;

  typedef struct packed {
    logic       valid;
    logic       is_data;
    logic [1:0] offset;
    t_mem_size  size;
    logic       sign;
  } t_rd_pipe;

  localparam logic [3:0] SIZE_BYTE_CODE = 4'b0001;
  localparam logic [3:0] SIZE_HALF_CODE = 4'b0011;
  localparam logic [3:0] SIZE_WORD_CODE = 4'b1111;

  function automatic t_mem_size decode_size(input logic [3:0] be);
    case (be)
      SIZE_BYTE_CODE: decode_size = BYTE;
      SIZE_HALF_CODE: decode_size = HALF;
      default:        decode_size = WORD;
    endcase
  endfunction

  // Right-align the addressed lane of a full word and extend to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  offset,
                                               input t_mem_size   size,
                                               input logic        sign);
    logic [31:0] shifted;
    shifted = word >> {offset, 3'b000};
    case (size)
      BYTE:    lane_extract = {{24{sign & shifted[7]}}, shifted[7:0]};
      HALF:    lane_extract = {{16{sign & shifted[15]}}, shifted[15:0]};
      default: lane_extract = shifted;
    endcase
  endfunction

endpackage

// File: rtl/rvc_mem_arb.sv
// Single-port arbiter: data wins by default, fetch wins when data is idle
// or after STARVE_MAX consecutive lost cycles.
module rvc_mem_arb #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic Clock,
  input  logic Rst,
  input  logic IReq,
  input  logic DReq,
  output logic IReady,
  output logic DReady,
  output logic sel_data
);
  localparam int unsigned CW = ($clog2(STARVE_MAX + 1) > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CW-1:0] starve;
  logic          starved;

  assign starved  = (starve == CW'(STARVE_MAX));
  assign sel_data = DReq && !(IReq && starved);
  assign IReady   = Rst && IReq && !sel_data;
  assign DReady   = Rst && sel_data;

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      starve <= '0;
    end else if (!IReq || IReady) begin
      starve <= '0;
    end else if (!starved) begin
      starve <= starve + 1'b1;
    end
  end

endmodule

// File: rtl/rvc_mem_ctrl.sv
// Unified fetch/data controller over one word array: byte-lane stores,
// pipelined in-order reads of RD_LAT cycles, and access-error detection.
module rvc_mem_ctrl
  import rvc_asap_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic        IReady,
  output logic        IRdValid,
  output logic [31:0] IRdData,
  input  logic        DReq,
  input  logic        DWrEn,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWrData,
  input  logic [3:0]  DByteEn,
  input  logic        DSignExt,
  output logic        DReady,
  output logic        DRdValid,
  output logic [31:0] DRdData,
  output logic        AccessErr
);
  localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  logic          sel_data, i_acc, d_acc, d_err, d_in_range, i_in_range;
  t_mem_size     d_size;
  logic [AW-1:0] d_idx, i_idx, rd_idx;
  logic [3:0]    lane_mask;
  logic [31:0]   wr_rep, rd_word, in_word, tail_word;
  t_rd_pipe      in_info, tail_info;

  rvc_mem_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .Clock    (Clock),
    .Rst      (Rst),
    .IReq     (IReq),
    .DReq     (DReq),
    .IReady   (IReady),
    .DReady   (DReady),
    .sel_data (sel_data)
  );

  assign i_acc      = IReq && IReady;
  assign d_acc      = DReq && DReady;
  assign d_size     = decode_size(DByteEn);
  assign d_in_range = DAddr < MEM_BYTES;
  assign i_in_range = IAddr < MEM_BYTES;
  assign d_idx      = DAddr[AW+1:2];
  assign i_idx      = IAddr[AW+1:2];
  assign rd_idx     = sel_data ? d_idx : i_idx;
  assign rd_word    = mem[rd_idx];
  assign lane_mask  = DByteEn << DAddr[1:0];

  always_comb begin
    d_err  = !d_in_range;
    wr_rep = DWrData;
    case (d_size)
      BYTE: wr_rep = {4{DWrData[7:0]}};
      HALF: begin
        wr_rep = {2{DWrData[15:0]}};
        if (DAddr[0]) d_err = 1'b1;
      end
      default: if (DAddr[1:0] != 2'b00) d_err = 1'b1;
    endcase
  end

  // Array write lands at the accept edge, so a load accepted next cycle sees it.
  always_ff @(posedge Clock) begin
    if (d_acc && DWrEn && !d_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (lane_mask[b]) mem[d_idx][8*b +: 8] <= wr_rep[8*b +: 8];
      end
    end
  end

  always_comb begin
    in_info         = '0;
    in_word         = '0;
    in_info.valid   = (d_acc && !DWrEn) || i_acc;
    in_info.is_data = d_acc;
    in_info.offset  = DAddr[1:0];
    in_info.size    = d_size;
    in_info.sign    = DSignExt;
    if (d_acc) begin
      in_word = d_err ? '0 : rd_word;
    end else if (i_acc && i_in_range) begin
      in_word = rd_word;
    end
  end

  // The output register is the last latency stage; extra stages sit in front.
  if (RD_LAT > 1) begin : g_pipe
    t_rd_pipe    st_info [RD_LAT-1];
    logic [31:0] st_word [RD_LAT-1];

    always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
        for (int unsigned k = 0; k < RD_LAT - 1; k++) begin
          st_info[k] <= '0;
          st_word[k] <= '0;
        end
      end else begin
        st_info[0] <= in_info;
        st_word[0] <= in_word;
        for (int unsigned k = 1; k < RD_LAT - 1; k++) begin
          st_info[k] <= st_info[k-1];
          st_word[k] <= st_word[k-1];
        end
      end
    end

    assign tail_info = st_info[RD_LAT-2];
    assign tail_word = st_word[RD_LAT-2];
  end else begin : g_direct
    assign tail_info = in_info;
    assign tail_word = in_word;
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      IRdValid  <= 1'b0;
      IRdData   <= '0;
      DRdValid  <= 1'b0;
      DRdData   <= '0;
      AccessErr <= 1'b0;
    end else begin
      IRdValid  <= tail_info.valid && !tail_info.is_data;
      DRdValid  <= tail_info.valid && tail_info.is_data;
      AccessErr <= d_acc && d_err;
      if (tail_info.valid && !tail_info.is_data) IRdData <= tail_word;
      if (tail_info.valid && tail_info.is_data) begin
        DRdData <= lane_extract(tail_word, tail_info.offset, tail_info.size, tail_info.sign);
      end
    end
  end

endmodule
